// File: rtl/multiport_register_file.sv
`default_nettype none
// ============================================================================
// Module   : multiport_register_file
// Purpose  : Two-read / two-write register file with fixed write priority,
//            optional hardwired zero register, optional write-to-read bypass
//            and a reset-initiated clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module multiport_register_file #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write_a,
  input  logic [ADDR_W-1:0] write_reg_a,
  input  logic [DATA_W-1:0] write_data_a,
  input  logic              reg_write_b,
  input  logic [ADDR_W-1:0] write_reg_b,
  input  logic [DATA_W-1:0] write_data_b,
  output logic              busy
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                w_we_a, w_we_b;
  logic [ADDR_W-1:0]   w_raddr [2];
  logic [DATA_W-1:0]   w_rdata [2];

  // An address is usable when it is inside the array and is not the
  // hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < $unsigned(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == C_LAST_IDX) begin
          state_d   = READY;
          clr_idx_d = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign busy   = (state_q != READY);
  assign w_we_a = !busy && reg_write_a && addr_ok(write_reg_a);
  assign w_we_b = !busy && reg_write_b && addr_ok(write_reg_b);

  // Port B is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[clr_idx_q] <= '0;
      end else begin
        if (w_we_a) mem_q[write_reg_a] <= write_data_a;
        if (w_we_b) mem_q[write_reg_b] <= write_data_b;
      end
    end
  end

  assign w_raddr[0] = read_reg1;
  assign w_raddr[1] = read_reg2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      if (!busy && addr_ok(w_raddr[p])) begin
        if ((BYPASS != 0) && w_we_b && (write_reg_b == w_raddr[p]))
          w_rdata[p] = write_data_b;
        else if ((BYPASS != 0) && w_we_a && (write_reg_a == w_raddr[p]))
          w_rdata[p] = write_data_a;
        else
          w_rdata[p] = mem_q[w_raddr[p]];
      end
    end
  end

  assign read_data1 = w_rdata[0];
  assign read_data2 = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_multiport_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiport_register_file
// Purpose  : Directed self-checking bench for three register-file variants
//            (bypass, no-bypass, 24-deep) driven from shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiport_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_reg1, read_reg2, write_reg_a, write_reg_b;
  logic        reg_write_a, reg_write_b;
  logic [31:0] write_data_a, write_data_b;

  logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0, rd1_d24, rd2_d24;
  logic        busy_b1, busy_b0, busy_d24;

  int passed = 0;
  int total  = 0;
  int errs;
  logic [31:0] exp24 [24];

  always #5 clk = ~clk;

  multiport_register_file #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_b1 (
    .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b1), .read_data2(rd2_b1),
    .reg_write_a(reg_write_a), .write_reg_a(write_reg_a), .write_data_a(write_data_a),
    .reg_write_b(reg_write_b), .write_reg_b(write_reg_b), .write_data_b(write_data_b),
    .busy(busy_b1));

  multiport_register_file #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_b0 (
    .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b0), .read_data2(rd2_b0),
    .reg_write_a(reg_write_a), .write_reg_a(write_reg_a), .write_data_a(write_data_a),
    .reg_write_b(reg_write_b), .write_reg_b(write_reg_b), .write_data_b(write_data_b),
    .busy(busy_b0));

  multiport_register_file #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_d24 (
    .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_d24), .read_data2(rd2_d24),
    .reg_write_a(reg_write_a), .write_reg_a(write_reg_a), .write_data_a(write_data_a),
    .reg_write_b(reg_write_b), .write_reg_b(write_reg_b), .write_data_b(write_data_b),
    .busy(busy_d24));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_writes();
    reg_write_a = 1'b0;
    reg_write_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    read_reg1 = '0; read_reg2 = '0;
    reg_write_a = 1'b0; write_reg_a = '0; write_data_a = '0;
    reg_write_b = 1'b0; write_reg_b = '0; write_data_b = '0;

    // Reset held for two edges, then a sweep with a write that must be lost.
    tick(); tick();
    check("busy_in_reset", 32'(busy_b1), 32'd1);
    rst = 1'b0;
    reg_write_a = 1'b1; write_reg_a = 5'd5; write_data_a = 32'h0000_1234;
    read_reg1 = 5'd5;
    #1;
    check("read_while_busy", rd1_b1, 32'h0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 5) idle_writes();
    end
    check("busy_after_31", 32'(busy_b1), 32'd1);
    tick();
    check("busy_after_32_b1", 32'(busy_b1), 32'd0);
    check("busy_after_32_b0", 32'(busy_b0), 32'd0);
    check("busy_d24_done", 32'(busy_d24), 32'd0);
    #1;
    check("sweep_write_lost", rd1_b1, 32'h0);
    errs = 0;
    for (int a = 0; a < 32; a++) begin
      read_reg1 = 5'(a); read_reg2 = 5'(31 - a);
      #1;
      if (rd1_b1 !== 32'h0 || rd2_b1 !== 32'h0 || rd1_b0 !== 32'h0) errs++;
    end
    check("all_regs_zero", 32'(errs), 32'd0);

    // Reset asserted at clr_idx == 10 restarts the sweep from index 0.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    check("restart_busy_31", 32'(busy_b1), 32'd1);
    tick();
    check("restart_busy_32", 32'(busy_b1), 32'd0);

    // Dual write to distinct addresses on one edge.
    read_reg1 = 5'd2; read_reg2 = 5'd3;
    reg_write_a = 1'b1; write_reg_a = 5'd1;  write_data_a = 32'h0000_FFFF;
    reg_write_b = 1'b1; write_reg_b = 5'd30; write_data_b = 32'hFFFF_0000;
    tick();
    idle_writes();
    read_reg1 = 5'd1; read_reg2 = 5'd30;
    #1;
    check("dual_a_reg1", rd1_b1, 32'h0000_FFFF);
    check("dual_b_reg30", rd2_b1, 32'hFFFF_0000);
    check("dual_b0_reg1", rd1_b0, 32'h0000_FFFF);
    check("d24_reg1", rd1_d24, 32'h0000_FFFF);
    check("d24_reg30_oob", rd2_d24, 32'h0);

    // Same-address collision: port B wins, both on bypass and in storage.
    read_reg1 = 5'd7; read_reg2 = 5'd0;
    reg_write_a = 1'b1; write_reg_a = 5'd7; write_data_a = 32'hAAAA_AAAA;
    reg_write_b = 1'b1; write_reg_b = 5'd7; write_data_b = 32'h5555_5555;
    #1;
    check("bypass_double_match", rd1_b1, 32'h5555_5555);
    check("nobypass_old_r7", rd1_b0, 32'h0);
    tick();
    idle_writes();
    #1;
    check("conflict_b1", rd1_b1, 32'h5555_5555);
    check("conflict_b0", rd1_b0, 32'h5555_5555);

    // Single-port bypass versus registered visibility.
    read_reg1 = 5'd9;
    reg_write_a = 1'b1; write_reg_a = 5'd9; write_data_a = 32'hDEAD_BEEF;
    #1;
    check("bypass_same_cycle", rd1_b1, 32'hDEAD_BEEF);
    check("nobypass_same_cycle", rd1_b0, 32'h0);
    tick();
    idle_writes();
    #1;
    check("nobypass_next_cycle", rd1_b0, 32'hDEAD_BEEF);
    check("bypass_next_cycle", rd1_b1, 32'hDEAD_BEEF);

    // Writes to the zero register never show, even via bypass.
    read_reg1 = 5'd0;
    reg_write_b = 1'b1; write_reg_b = 5'd0; write_data_b = 32'hFFFF_FFFF;
    #1;
    check("zero_reg_bypass", rd1_b1, 32'h0);
    tick();
    idle_writes();
    #1;
    check("zero_reg_b1", rd1_b1, 32'h0);
    check("zero_reg_b0", rd1_b0, 32'h0);

    // Out-of-range write on the 24-deep variant is dropped with no aliasing.
    read_reg2 = 5'd25;
    reg_write_a = 1'b1; write_reg_a = 5'd25; write_data_a = 32'hCAFE_F00D;
    #1;
    check("d24_oob_bypass", rd2_d24, 32'h0);
    tick();
    idle_writes();
    #1;
    check("d24_oob_read", rd2_d24, 32'h0);
    check("b1_reg25_written", rd2_b1, 32'hCAFE_F00D);
    for (int a = 0; a < 24; a++) exp24[a] = 32'h0;
    exp24[1] = 32'h0000_FFFF;
    exp24[7] = 32'h5555_5555;
    exp24[9] = 32'hDEAD_BEEF;
    errs = 0;
    for (int a = 0; a < 24; a++) begin
      read_reg1 = 5'(a);
      #1;
      if (rd1_d24 !== exp24[a]) errs++;
    end
    check("d24_contents", 32'(errs), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
